// File: rtl/mult_shift_add_core.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock, product held with done.
// Optional macro MULT_EARLY_DONE_EN ends the run as soon as the remaining multiplier bits are zero.
module mult_shift_add_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [2*WIDTH-1:0]   mcand_r, mcand_s;
    logic [2*WIDTH-1:0]   pp_r, pp_s;
    logic [WIDTH-1:0]     mpr_r, mpr_s;
    logic [CW-1:0]        count_r, count_s;
    logic                 done_r, done_s;
    logic                 busy_r, busy_s;
    logic                 last_step_s;

    // Exit test uses pre-shift values so the final addition lands on the exit edge
    always_comb begin
`ifdef MULT_EARLY_DONE_EN
        last_step_s = (count_r == CW'(WIDTH - 1)) || (mpr_r[WIDTH-1:1] == '0);
`else
        last_step_s = (count_r == CW'(WIDTH - 1));
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_s = state_r;
        mcand_s = mcand_r;
        pp_s    = pp_r;
        mpr_s   = mpr_r;
        count_s = count_r;
        done_s  = done_r;
        busy_s  = busy_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (init) begin
                    state_s = ST_RUN;
                    mcand_s = {{WIDTH{1'b0}}, A};
                    mpr_s   = B;
                    pp_s    = '0;
                    count_s = '0;
                    done_s  = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (mpr_r[0]) begin
                    pp_s = pp_r + mcand_r;
                end else begin
                    pp_s = pp_r;
                end
                mcand_s = mcand_r << 1;
                mpr_s   = mpr_r >> 1;
                count_s = count_r + CW'(1);
                if (last_step_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                mcand_s = '0;
                pp_s    = '0;
                mpr_s   = '0;
                count_s = '0;
                done_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            mcand_r <= '0;
            pp_r    <= '0;
            mpr_r   <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mcand_r <= mcand_s;
            pp_r    <= pp_s;
            mpr_r   <= mpr_s;
            count_r <= count_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign pp   = pp_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule
